// File: rtl/decode_queue.sv
// In-order multi-lane decoded-packet queue with 8-bit itag stamping; optional DECODE_QUEUE_BYPASS_EN.
// Latency: 1 cycle enqueue-to-dequeue (0 with bypass when empty); outputs read combinationally from storage.
// Backpressure: all-or-nothing enq_ready_o from registered count; dequeue consumes the ready prefix.
module decode_queue #(
    parameter int PKT_W = 160,
    parameter int DEPTH = 8,
    parameter int LANES = 2
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       flush_i,
    input  logic [LANES-1:0]           enq_valid_i,
    input  logic [LANES*PKT_W-1:0]     enq_pkt_i,
    output logic                       enq_ready_o,
    output logic [LANES-1:0]           deq_valid_o,
    input  logic [LANES-1:0]           deq_ready_i,
    output logic [LANES*PKT_W-1:0]     deq_pkt_o,
    output logic [LANES*8-1:0]         deq_itag_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(LANES + 1);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - LANES);

    typedef struct packed {
        logic [PKT_W-1:0] pkt;
        logic [7:0]       itag;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [7:0]      itag_nxt;
    logic [NW-1:0]   n_enq;
    logic [NW-1:0]   n_deq;
    logic            byp;

`ifdef DECODE_QUEUE_BYPASS_EN
    assign byp = (count == '0) && !flush_i;
`else
    assign byp = 1'b0;
`endif

    // Ready only looks at the registered count so there is no path from deq_ready_i.
    assign enq_ready_o = (count <= READY_MAX);
    assign count_o     = count;
    assign empty_o     = (count == '0);
    assign full_o      = (count == CW'(DEPTH));

    always_comb begin
        n_enq = '0;
        for (int i = 0; i < LANES; i++) begin
            if (enq_ready_o && enq_valid_i[i] && n_enq == NW'(i))
                n_enq = n_enq + NW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            deq_valid_o[i]              = (count > CW'(i));
            deq_pkt_o[i*PKT_W +: PKT_W] = mem[head + PW'(i)].pkt;
            deq_itag_o[i*8 +: 8]        = mem[head + PW'(i)].itag;
        end
`ifdef DECODE_QUEUE_BYPASS_EN
        if (byp) begin
            for (int i = 0; i < LANES; i++) begin
                deq_valid_o[i]              = (NW'(i) < n_enq);
                deq_pkt_o[i*PKT_W +: PKT_W] = enq_pkt_i[i*PKT_W +: PKT_W];
                deq_itag_o[i*8 +: 8]        = itag_nxt + 8'(i);
            end
        end
`endif
    end

    always_comb begin
        n_deq = '0;
        for (int i = 0; i < LANES; i++) begin
            if (deq_valid_o[i] && deq_ready_i[i] && n_deq == NW'(i))
                n_deq = n_deq + NW'(1);
        end
    end

    // Lanes consumed straight through the bypass keep their slot position but skip the write.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            itag_nxt <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (NW'(i) < n_enq && !(byp && NW'(i) < n_deq))
                    mem[tail + PW'(i)] <= '{pkt: enq_pkt_i[i*PKT_W +: PKT_W],
                                           itag: itag_nxt + 8'(i)};
            end
            tail     <= tail + PW'(n_enq);
            head     <= head + PW'(n_deq);
            count    <= count + CW'(n_enq) - CW'(n_deq);
            itag_nxt <= itag_nxt + 8'(n_enq);
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// Randomized bench for decode_queue against a queue-based reference model.
module tb_decode_queue;
    localparam int PKT_W = 160;
    localparam int DEPTH = 8;
    localparam int LANES = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                   clk       = 1'b0;
    logic                   arst      = 1'b1;
    logic                   flush     = 1'b0;
    logic [LANES-1:0]       enq_valid = '0;
    logic [LANES-1:0]       deq_ready = '0;
    logic [LANES*PKT_W-1:0] enq_pkt   = '0;
    logic                   enq_ready;
    logic                   empty;
    logic                   full;
    logic [LANES-1:0]       deq_valid;
    logic [LANES*PKT_W-1:0] deq_pkt;
    logic [LANES*8-1:0]     deq_itag;
    logic [CW-1:0]          count;

    decode_queue #(.PKT_W(PKT_W), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .flush_i     (flush),
        .enq_valid_i (enq_valid),
        .enq_pkt_i   (enq_pkt),
        .enq_ready_o (enq_ready),
        .deq_valid_o (deq_valid),
        .deq_ready_i (deq_ready),
        .deq_pkt_o   (deq_pkt),
        .deq_itag_o  (deq_itag),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PKT_W-1:0] pkt;
        logic [7:0]       itag;
    } ent_t;

    ent_t q[$];
    int   itag_m = 0;
    int   tests  = 0;
    int   fails  = 0;

    task automatic check(input string tag, input logic [PKT_W-1:0] got, input logic [PKT_W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PKT_W-1:0] rand_pkt();
        logic [PKT_W-1:0] p;
        for (int w = 0; w < PKT_W / 32; w++)
            p[w*32 +: 32] = $urandom();
        return p;
    endfunction

    task automatic check_reset(input string ctx);
        check({ctx, " deq_valid"}, PKT_W'(deq_valid), '0);
        check({ctx, " count"},     PKT_W'(count), '0);
        check({ctx, " empty"},     PKT_W'(empty), PKT_W'(1));
        check({ctx, " full"},      PKT_W'(full), '0);
        check({ctx, " enq_ready"}, PKT_W'(enq_ready), PKT_W'(1));
        for (int i = 0; i < LANES; i++) begin
            check($sformatf("%s pkt%0d", ctx, i),  deq_pkt[i*PKT_W +: PKT_W], '0);
            check($sformatf("%s itag%0d", ctx, i), PKT_W'(deq_itag[i*8 +: 8]), '0);
        end
    endtask

    task automatic check_state(input string ctx);
        int sz;
        sz = q.size();
        check({ctx, " count"},     PKT_W'(count), PKT_W'(sz));
        check({ctx, " empty"},     PKT_W'(empty), PKT_W'(sz == 0));
        check({ctx, " full"},      PKT_W'(full), PKT_W'(sz == DEPTH));
        check({ctx, " enq_ready"}, PKT_W'(enq_ready), PKT_W'(DEPTH - sz >= LANES));
        for (int i = 0; i < LANES; i++) begin
            check($sformatf("%s valid%0d", ctx, i), PKT_W'(deq_valid[i]), PKT_W'(i < sz));
            if (i < sz) begin
                check($sformatf("%s pkt%0d", ctx, i),  deq_pkt[i*PKT_W +: PKT_W], q[i].pkt);
                check($sformatf("%s itag%0d", ctx, i), PKT_W'(deq_itag[i*8 +: 8]), PKT_W'(q[i].itag));
            end
        end
    endtask

    // Reference: occupancy limit, prefix rules and itag numbering applied to a plain queue.
    task automatic model_edge();
        int  ne;
        int  nd;
        bit  rdy;
        ent_t e;
        ne  = 0;
        nd  = 0;
        rdy = (DEPTH - q.size() >= LANES);
        for (int i = 0; i < LANES; i++)
            if (rdy && enq_valid[i] && ne == i) ne++;
        for (int i = 0; i < LANES; i++)
            if (i < q.size() && deq_ready[i] && nd == i) nd++;
        if (flush) begin
            q.delete();
        end else begin
            repeat (nd) void'(q.pop_front());
            for (int i = 0; i < ne; i++) begin
                e.pkt  = enq_pkt[i*PKT_W +: PKT_W];
                e.itag = 8'((itag_m + i) % 256);
                q.push_back(e);
            end
            itag_m = (itag_m + ne) % 256;
        end
    endtask

    task automatic step(input logic [LANES-1:0] ev, input logic [LANES-1:0] dr, input logic fl);
        enq_valid = ev;
        deq_ready = dr;
        flush     = fl;
        for (int i = 0; i < LANES; i++)
            enq_pkt[i*PKT_W +: PKT_W] = rand_pkt();
        @(negedge clk);
        check_state("cyc");
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_reset("reset");
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;

        step(2'b11, 2'b00, 1'b0);
        check("first count", PKT_W'(count), PKT_W'(2));
        check("first pktA", deq_pkt[0 +: PKT_W], enq_pkt[0 +: PKT_W]);
        check("first pktB", deq_pkt[PKT_W +: PKT_W], enq_pkt[PKT_W +: PKT_W]);
        check("first itag0", PKT_W'(deq_itag[7:0]), PKT_W'(0));
        check("first itag1", PKT_W'(deq_itag[15:8]), PKT_W'(1));

        step(2'b10, 2'b00, 1'b0);
        check("nonprefix enq", PKT_W'(count), PKT_W'(2));
        step(2'b00, 2'b10, 1'b0);
        check("nonprefix deq", PKT_W'(count), PKT_W'(2));
        step(2'b01, 2'b00, 1'b0);
        step(2'b11, 2'b01, 1'b0);
        check("enq2 deq1", PKT_W'(count), PKT_W'(4));

        step(2'b11, 2'b00, 1'b1);
        check("flush count", PKT_W'(count), '0);
        check("flush empty", PKT_W'(empty), PKT_W'(1));
        step(2'b01, 2'b00, 1'b0);
        check("flush itag", PKT_W'(deq_itag[7:0]), PKT_W'(5));

        repeat (3) step(2'b11, 2'b00, 1'b0);
        check("cnt7 ready", PKT_W'(enq_ready), '0);
        step(2'b01, 2'b00, 1'b0);
        check("cnt7 hold", PKT_W'(count), PKT_W'(7));
        step(2'b00, 2'b01, 1'b0);
        step(2'b11, 2'b00, 1'b0);
        check("full flag", PKT_W'(full), PKT_W'(1));
        check("full ready", PKT_W'(enq_ready), '0);
        step(2'b11, 2'b00, 1'b0);
        check("full hold", PKT_W'(count), PKT_W'(8));
        step(2'b11, 2'b11, 1'b0);
        check("full enq+deq", PKT_W'(count), PKT_W'(6));

        for (int n = 0; n < 800; n++)
            step(LANES'($urandom_range(0, 3)), LANES'($urandom_range(0, 3)), $urandom_range(0, 39) == 0);

        step(2'b11, 2'b00, 1'b0);
        enq_valid = '0;
        deq_ready = '0;
        flush     = 1'b0;
        #2;
        arst = 1'b1;
        #1;
        check_reset("midreset");
        q.delete();
        itag_m = 0;
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 50; n++)
            step(LANES'($urandom_range(0, 3)), LANES'($urandom_range(0, 3)), 1'b0);
        @(negedge clk);
        check_state("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
